// File: rtl/heap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : heap_ctrl
//  Description : Frame sequencer for a hardware sort heap. Accepts a key
//                stream, issues paced insert strobes into the heap, flushes
//                it, waits out the drain window and forwards heap output
//                words as a key result stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module heap_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int KEY_WIDTH  = 16,
  parameter int NLEVELS    = 2,
  parameter int ISSUE_GAP  = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  // key stream in
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [KEY_WIDTH-1:0]  s_key,
  input  logic                  s_last,
  // heap control
  output logic                  h_init,
  output logic                  h_en,
  output logic                  h_flush,
  output logic [DATA_WIDTH-1:0] h_din,
  input  logic                  h_valid,
  input  logic [DATA_WIDTH-1:0] h_dout,
  // result stream out
  output logic                  m_valid,
  output logic [KEY_WIDTH-1:0]  m_key,
  // status
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           in_cnt,
  output logic [15:0]           out_cnt
);

  localparam int HEAP_SIZE    = (1 << (NLEVELS + 1)) - 1;
  localparam int DRAIN_CYCLES = 2 * HEAP_SIZE + 4;

  // A one-cycle gap still needs a 1-bit counter so the compare logic exists.
  localparam int GAP_W   = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES);

  localparam logic [GAP_W-1:0]   C_GAP_LOAD   = GAP_W'(ISSUE_GAP - 1);
  localparam logic [GAP_W-1:0]   C_GAP_ONE    = GAP_W'(1);
  localparam logic [DRAIN_W-1:0] C_DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [DRAIN_W-1:0] C_DRAIN_ONE  = DRAIN_W'(1);
  localparam logic [15:0]        C_CNT_MAX    = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    LOAD  = 3'd2,
    FLUSH = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [GAP_W-1:0]      r_gap;
  logic [DRAIN_W-1:0]    r_drain;

  logic                  r_h_init;
  logic                  r_h_en;
  logic                  r_h_flush;
  logic [DATA_WIDTH-1:0] r_h_din;
  logic                  r_m_valid;
  logic [KEY_WIDTH-1:0]  r_m_key;
  logic                  r_done;
  logic [15:0]           r_in_cnt;
  logic [15:0]           r_out_cnt;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_init_go;
  logic                  w_flush_go;
  logic                  w_done_go;
  logic                  w_busy;

  // Only the key field of a heap word is forwarded; the pad bits are ignored.
  logic                  w_unused_dout;
  assign w_unused_dout = ^h_dout[DATA_WIDTH-1:KEY_WIDTH];

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus the one-cycle strobe requests derived from it.
  // start is honoured only in IDLE and not while the completion pulse of the
  // previous frame is still on the port, so a start overlapping done is lost.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_accept    = 1'b0;
    w_init_go   = 1'b0;
    w_flush_go  = 1'b0;
    w_done_go   = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (start && !r_done) begin
          w_state_nxt = INIT;
          w_init_go   = 1'b1;
        end
      end
      INIT: begin
        w_state_nxt = LOAD;
      end
      LOAD: begin
        w_ready  = (r_gap == '0);
        w_accept = w_ready && s_valid;
        if (w_accept && s_last) begin
          w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (r_gap == '0) begin
          w_state_nxt = DRAIN;
          w_flush_go  = 1'b1;
        end
      end
      DRAIN: begin
        if (r_drain == C_DRAIN_LAST) begin
          w_state_nxt = IDLE;
          w_done_go   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Insert pacing: reload after every accept, count down to zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_gap <= '0;
    end else if (w_init_go) begin
      r_gap <= '0;
    end else if (w_accept) begin
      r_gap <= C_GAP_LOAD;
    end else if (r_gap != '0) begin
      r_gap <= r_gap - C_GAP_ONE;
    end
  end

  // Drain window counter, idle at zero outside DRAIN.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_drain <= '0;
    end else if (r_state == DRAIN && !w_done_go) begin
      r_drain <= r_drain + C_DRAIN_ONE;
    end else begin
      r_drain <= '0;
    end
  end

  // Registered heap strobes; each comes from a different state so they can
  // never overlap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_h_init  <= 1'b0;
      r_h_en    <= 1'b0;
      r_h_flush <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_h_init  <= w_init_go;
      r_h_en    <= w_accept;
      r_h_flush <= w_flush_go;
      r_done    <= w_done_go;
    end
  end

  // Heap input word: accepted key zero-extended into the data word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_h_din <= '0;
    end else if (w_accept) begin
      r_h_din <= {{(DATA_WIDTH - KEY_WIDTH){1'b0}}, s_key};
    end
  end

  // Accepted-key counter, cleared at frame start, saturating.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_in_cnt <= '0;
    end else if (w_init_go) begin
      r_in_cnt <= '0;
    end else if (w_accept && r_in_cnt != C_CNT_MAX) begin
      r_in_cnt <= r_in_cnt + 16'd1;
    end
  end

  // Result stream: one-cycle-late copy of the heap output key field.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_m_valid <= 1'b0;
      r_m_key   <= '0;
    end else begin
      r_m_valid <= h_valid;
      if (h_valid) begin
        r_m_key <= h_dout[KEY_WIDTH-1:0];
      end
    end
  end

  // Emitted-result counter, cleared at frame start, saturating.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_cnt <= '0;
    end else if (w_init_go) begin
      r_out_cnt <= '0;
    end else if (h_valid && r_out_cnt != C_CNT_MAX) begin
      r_out_cnt <= r_out_cnt + 16'd1;
    end
  end

  assign s_ready = w_ready;
  assign busy    = w_busy;
  assign h_init  = r_h_init;
  assign h_en    = r_h_en;
  assign h_flush = r_h_flush;
  assign h_din   = r_h_din;
  assign m_valid = r_m_valid;
  assign m_key   = r_m_key;
  assign done    = r_done;
  assign in_cnt  = r_in_cnt;
  assign out_cnt = r_out_cnt;

endmodule
`default_nettype wire

// File: tb/tb_heap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_heap_ctrl
//  Description : Randomised scoreboard bench for heap_ctrl. Stimulus pushes
//                expected heap words / result keys into queues; a negedge
//                monitor pops and compares whenever the DUT strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_heap_ctrl;

  localparam int DATA_WIDTH   = 32;
  localparam int KEY_WIDTH    = 16;
  localparam int NLEVELS      = 2;
  localparam int ISSUE_GAP    = 2;
  localparam int HEAP_SIZE    = (1 << (NLEVELS + 1)) - 1;
  localparam int DRAIN_CYCLES = 2 * HEAP_SIZE + 4;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic                  start = 1'b0;
  logic                  s_valid = 1'b0;
  logic                  s_ready;
  logic [KEY_WIDTH-1:0]  s_key = '0;
  logic                  s_last = 1'b0;
  logic                  h_init, h_en, h_flush;
  logic [DATA_WIDTH-1:0] h_din;
  logic                  h_valid = 1'b0;
  logic [DATA_WIDTH-1:0] h_dout = '0;
  logic                  m_valid;
  logic [KEY_WIDTH-1:0]  m_key;
  logic                  busy, done;
  logic [15:0]           in_cnt, out_cnt;

  heap_ctrl #(
    .DATA_WIDTH(DATA_WIDTH), .KEY_WIDTH(KEY_WIDTH),
    .NLEVELS(NLEVELS), .ISSUE_GAP(ISSUE_GAP)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_key(s_key), .s_last(s_last),
    .h_init(h_init), .h_en(h_en), .h_flush(h_flush), .h_din(h_din),
    .h_valid(h_valid), .h_dout(h_dout),
    .m_valid(m_valid), .m_key(m_key),
    .busy(busy), .done(done), .in_cnt(in_cnt), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Scoreboard queues: {key, expected count} per expected strobe.
  logic [31:0] din_q[$];
  logic [31:0] mk_q[$];
  int          hen_cyc[$];

  int  flush_cyc = 0, done_cyc = 0;
  int  n_init = 0, n_flush = 0, n_done = 0;
  bit  prev_busy = 1'b0;
  bit  hv_on = 1'b0;
  bit  force_a7 = 1'b0;
  int  out_model = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_strobes"}, {h_init, h_en, h_flush, s_ready, m_valid, done, busy}, 0);
    chk({nm, "_data"}, {h_din, m_key, in_cnt, out_cnt}, 0);
  endtask

  // Heap output driver: random result words while enabled.
  initial begin
    logic [DATA_WIDTH-1:0] w;
    forever begin
      @(posedge clk); #1;
      if (hv_on && rstn && (force_a7 || $urandom_range(0, 2) == 0)) begin
        w = force_a7 ? {16'h1234, 16'h00A7} : $urandom;
        force_a7 = 1'b0;
        h_valid = 1'b1;
        h_dout  = w;
        out_model = (out_model < 65535) ? out_model + 1 : 65535;
        mk_q.push_back({w[15:0], 16'(out_model)});
      end else begin
        h_valid = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT strobes an output.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rstn) begin
      if (h_en || h_init || h_flush)
        chk("strobe_onehot", $countones({h_en, h_init, h_flush}), 1);
      if (h_en) begin
        hen_cyc.push_back(cyc);
        if (din_q.size() == 0) chk("h_en_unexpected", 1, 0);
        else begin
          e = din_q.pop_front();
          chk("h_din", h_din, {16'h0000, e[31:16]});
          chk("in_cnt", in_cnt, e[15:0]);
        end
      end
      if (m_valid) begin
        if (mk_q.size() == 0) chk("m_valid_unexpected", 1, 0);
        else begin
          e = mk_q.pop_front();
          chk("m_key", m_key, e[31:16]);
          chk("out_cnt", out_cnt, e[15:0]);
        end
      end
      if (h_init) n_init++;
      if (h_flush) begin n_flush++; flush_cyc = cyc; end
      if (done) begin
        n_done++; done_cyc = cyc;
        chk("busy_at_done", busy, 0);
        chk("busy_before_done", prev_busy, 1);
      end
      prev_busy = busy;
    end
  end

  logic [15:0] keys[$];

  // One frame: start, stream keys, wait for flush/done and check timing.
  task automatic run_frame(input bit hold, input bit start_in_load,
                           input bit start_on_done, input bit abort);
    int i, n, budget, init0, flush0, in_model;
    bit acc, did;
    n = keys.size();
    hv_on = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    init0 = n_init; flush0 = n_flush;
    hen_cyc.delete();
    out_model = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("h_init_high", h_init, 1);
    @(posedge clk); #1;
    chk("h_init_one_cycle", h_init, 0);
    chk("load_s_ready", s_ready, 1);
    chk("load_busy", busy, 1);
    hv_on = 1'b1;
    i = 0; in_model = 0; did = 1'b0;
    s_key = keys[0]; s_last = (n == 1);
    s_valid = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
    budget = n * (ISSUE_GAP + 1) * 8 + 50;
    while (i < n && budget > 0) begin
      budget--;
      @(negedge clk);
      acc = s_valid && s_ready;
      if (acc) begin
        in_model++;
        din_q.push_back({keys[i], 16'(in_model)});
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (acc) begin
        i++;
        if (i < n) begin s_key = keys[i]; s_last = (i == n - 1); end
      end
      if (i < n) begin
        s_valid = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
        if (start_in_load && i == 1 && !did) begin start = 1'b1; did = 1'b1; end
      end else begin
        s_valid = 1'b0; s_last = 1'b0;
      end
    end
    if (i < n) chk("key_stream_timeout", i, n);
    if (abort) begin
      budget = 50;
      while (!h_flush && budget > 0) begin @(posedge clk); #1; budget--; end
      repeat (4) begin @(posedge clk); #1; end
      hv_on = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      chk("abort_in_drain_busy", busy, 1);
      #2 rstn = 1'b0;
      #1 chk_all_zero("async_reset");
      @(negedge clk); rstn = 1'b1;
      out_model = 0;
      repeat (4) begin @(posedge clk); #1; end
      chk("post_reset_idle", {busy, h_init, s_ready}, 0);
      chk("post_reset_no_init", n_init, init0 + 1);
      chk("post_reset_din_q", din_q.size(), 0);
      return;
    end
    budget = DRAIN_CYCLES + 8 * ISSUE_GAP + 20;
    while (!done && budget > 0) begin @(posedge clk); #1; budget--; end
    chk("done_seen", done, 1);
    if (start_on_done) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin
        @(posedge clk); #1;
        chk("start_on_done_ignored", {busy, h_init}, 0);
      end
    end else begin
      @(posedge clk); #1;
    end
    chk("init_count", n_init, init0 + 1);
    chk("flush_count", n_flush, flush0 + 1);
    chk("hen_count", hen_cyc.size(), n);
    if (hen_cyc.size() > 0)
      chk("flush_after_last_hen", flush_cyc - hen_cyc[hen_cyc.size() - 1], ISSUE_GAP);
    chk("done_after_flush", done_cyc - flush_cyc, DRAIN_CYCLES);
    chk("final_in_cnt", in_cnt, n);
    chk("din_q_drained", din_q.size(), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset_hold");
    @(negedge clk); rstn = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk_all_zero("after_release");

    // Directed frame: keys 5, 9, 3 with s_valid held; exact insert spacing.
    keys = '{16'd5, 16'd9, 16'd3};
    run_frame(1'b1, 1'b0, 1'b0, 1'b0);
    if (hen_cyc.size() == 3) begin
      chk("hen_spacing_0", hen_cyc[1] - hen_cyc[0], ISSUE_GAP);
      chk("hen_spacing_1", hen_cyc[2] - hen_cyc[1], ISSUE_GAP);
    end

    // Forced heap result 0x00A7 while idle.
    force_a7 = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    chk("a7_consumed", force_a7, 0);

    // Single-key frame.
    keys = '{16'hBEEF};
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);

    // Random frames, including start pulses during LOAD and on done.
    for (int f = 0; f < 6; f++) begin
      keys.delete();
      n = $urandom_range(2, 12);
      for (int k = 0; k < n; k++) keys.push_back(16'($urandom));
      run_frame(f[0], f == 1 || f == 4, f == 2 || f == 5, 1'b0);
    end

    // Frame abandoned by reset during DRAIN, then a clean frame after.
    keys = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    run_frame(1'b0, 1'b0, 1'b0, 1'b1);
    keys = '{16'h1111, 16'h2222};
    run_frame(1'b1, 1'b0, 1'b0, 1'b0);

    hv_on = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("mk_q_drained", mk_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog: a hung run still reports through the summary line.
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
